// File: rtl/multicycle_controller_if.sv
// Control interface between the multicycle RV32I controller and its datapath.
// master: controller side (consumes instruction fields / ALU flags / MemReady,
//         drives the datapath control strobes and selects).
// slave : datapath side (the mirror image).
// Signals:
//   op, funct3, funct7b5        instruction fields from the instruction register
//   Zero, Neg, Carry, Overflow  ALU flags (Carry = 1 means no borrow on subtract)
//   MemReady                    memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   RegWrite, ImmSrc, ALUControl  datapath controls
//   IllegalOp                   one-cycle pulse on an unsupported opcode
//   StateDbg                    current FSM state encoding
interface multicycle_controller_if #(
    parameter int ALUCTRL_W = 3
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 Zero;
    logic                 Neg;
    logic                 Carry;
    logic                 Overflow;
    logic                 MemReady;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic                 RegWrite;
    logic [2:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 IllegalOp;
    logic [3:0]           StateDbg;

    modport master (
        input  op, funct3, funct7b5, Zero, Neg, Carry, Overflow, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, IllegalOp, StateDbg
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Neg, Carry, Overflow, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, IllegalOp, StateDbg
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit. A single FSM walks each instruction through
// fetch / decode / execute / memory / writeback and drives the shared-memory
// datapath. Outputs are Moore per state, except IRWrite/PCWrite in FETCH
// (gated by memory readiness), PCWrite in BRANCH (branch taken), and
// ImmSrc/ALUControl, which are decoded from the instruction every cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; forces FETCH
//   bus    multicycle_controller_if.master (instruction fields, ALU flags,
//          MemReady in; datapath controls, IllegalOp, StateDbg out)
// Parameters:
//   ALUCTRL_W      3 = base ALU op set, 4 = adds shifts and sltu
//   USE_MEM_READY  1 = memory states wait for MemReady, 0 = MemReady ignored
module multicycle_controller #(
    parameter int ALUCTRL_W     = 3,
    parameter bit USE_MEM_READY = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t               state, next;
    aluop_t               aluop;
    logic                 rdy;
    logic                 taken;
    logic [ALUCTRL_W-1:0] ctrl;

    // Without the ready handshake every memory access is assumed to be single-cycle.
    assign rdy = USE_MEM_READY ? bus.MemReady : 1'b1;

    // Branch condition from the flags of rs1 - rs2.
    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = ~bus.Zero;
            3'b100:  taken = bus.Neg ^ bus.Overflow;
            3'b101:  taken = ~(bus.Neg ^ bus.Overflow);
            3'b110:  taken = ~bus.Carry;
            3'b111:  taken = bus.Carry;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    always_comb begin
        next          = state;
        aluop         = ALU_ADD;
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.RegWrite  = 1'b0;
        bus.IllegalOp = 1'b0;
        case (state)
            FETCH: begin
                // PC <= PC + 4 while the instruction word is captured.
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = rdy;
                bus.PCWrite   = rdy;
                if (rdy) next = DECODE;
            end
            DECODE: begin
                // OldPC + imm: branch/jal target lands in ALUOut.
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: next = MEMADR;
                    OP_RTYPE:          next = EXECR;
                    OP_ITYPE:          next = EXECI;
                    OP_JAL:            next = JAL;
                    OP_BRANCH:         next = BRANCH;
                    default:           next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                next        = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                if (rdy) next = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                next          = FETCH;
            end
            MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                if (rdy) next = FETCH;
            end
            EXECR: begin
                bus.ALUSrcA = 2'b10;
                aluop       = ALU_FUNCT;
                next        = ALUWB;
            end
            EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                aluop       = ALU_FUNCT;
                next        = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                next         = FETCH;
            end
            JAL: begin
                // Jump to the target computed in DECODE; ALU forms OldPC + 4 for rd.
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
                next        = ALUWB;
            end
            BRANCH: begin
                bus.ALUSrcA = 2'b10;
                aluop       = ALU_SUB;
                bus.PCWrite = taken;
                next        = FETCH;
            end
            ILLEGAL: begin
                bus.IllegalOp = 1'b1;
                next          = FETCH;
            end
            default: next = FETCH;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_STORE:         bus.ImmSrc = 3'b001;
            OP_BRANCH:        bus.ImmSrc = 3'b010;
            OP_JAL:           bus.ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: bus.ImmSrc = 3'b100;
            default:          bus.ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (aluop)
            ALU_ADD: ctrl = ALUCTRL_W'(0);
            ALU_SUB: ctrl = ALUCTRL_W'(1);
            default: begin
                case (bus.funct3)
                    // Only R-type (op[5]=1) uses funct7b5 to pick sub; addi never subtracts.
                    3'b000: ctrl = (bus.op[5] & bus.funct7b5) ? ALUCTRL_W'(1) : ALUCTRL_W'(0);
                    3'b111: ctrl = ALUCTRL_W'(2);
                    3'b110: ctrl = ALUCTRL_W'(3);
                    3'b100: ctrl = ALUCTRL_W'(4);
                    3'b010: ctrl = ALUCTRL_W'(5);
                    3'b001: ctrl = (ALUCTRL_W >= 4) ? ALUCTRL_W'(6) : ALUCTRL_W'(0);
                    3'b101: ctrl = (ALUCTRL_W >= 4) ? (bus.funct7b5 ? ALUCTRL_W'(8) : ALUCTRL_W'(7))
                                                    : ALUCTRL_W'(0);
                    3'b011: ctrl = (ALUCTRL_W >= 4) ? ALUCTRL_W'(9) : ALUCTRL_W'(0);
                    default: ctrl = ALUCTRL_W'(0);
                endcase
            end
        endcase
    end

    assign bus.ALUControl = ctrl;
    assign bus.StateDbg   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Two instances run side by side on the same
// inputs: u0 (ALUCTRL_W=3, no ready handshake) and u1 (ALUCTRL_W=4, ready
// handshake). Branch flags come from real operands a/b, and the reference
// model decides branches by comparing a and b directly.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        mr;
    logic [31:0] a, b, diff;

    always #5 clk = ~clk;

    assign diff = a - b;

    multicycle_controller_if #(.ALUCTRL_W(3)) b0 ();
    multicycle_controller_if #(.ALUCTRL_W(4)) b1 ();

    assign b0.op = op;  assign b0.funct3 = f3;  assign b0.funct7b5 = f7;  assign b0.MemReady = mr;
    assign b1.op = op;  assign b1.funct3 = f3;  assign b1.funct7b5 = f7;  assign b1.MemReady = mr;
    assign b0.Zero     = (diff == 32'd0);  assign b1.Zero     = (diff == 32'd0);
    assign b0.Neg      = diff[31];         assign b1.Neg      = diff[31];
    assign b0.Carry    = (a >= b);         assign b1.Carry    = (a >= b);
    assign b0.Overflow = (a[31] != b[31]) && (diff[31] != a[31]);
    assign b1.Overflow = (a[31] != b[31]) && (diff[31] != a[31]);

    multicycle_controller #(.ALUCTRL_W(3), .USE_MEM_READY(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    multicycle_controller #(.ALUCTRL_W(4), .USE_MEM_READY(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));

    int    checks = 0;
    int    errors = 0;
    int    st0, st1;
    string tag;

    // Expected outputs packed as
    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,ImmSrc,ALUControl[3:0],IllegalOp,StateDbg}
    function automatic logic [22:0] model(int st, int w, bit umr);
        logic       rdy, tk, pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [3:0] ac;
        int         aop;  // 0 add, 1 sub, 2 by funct
        rdy = umr ? mr : 1'b1;
        {pcw, adr, mw, irw, rw, ill} = '0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 0;
        case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) <  $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a <  b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
        endcase
        case (st)
            0:  begin sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1'b1;
            4:  begin rs = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin sa = 2'b10; aop = 2; end
            7:  rw = 1'b1;
            8:  begin sa = 2'b10; sb = 2'b01; aop = 2; end
            9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            10: begin sa = 2'b10; aop = 1; pcw = tk; end
            default: ill = 1'b1;
        endcase
        if (op == 7'b0100011)      imm = 3'd1;
        else if (op == 7'b1100011) imm = 3'd2;
        else if (op == 7'b1101111) imm = 3'd3;
        else if (op == 7'b0110111 || op == 7'b0010111) imm = 3'd4;
        else                       imm = 3'd0;
        ac = 4'd0;
        if (aop == 1) ac = 4'd1;
        else if (aop == 2) begin
            if (f3 == 3'd0)      ac = (op[5] && f7) ? 4'd1 : 4'd0;
            else if (f3 == 3'd7) ac = 4'd2;
            else if (f3 == 3'd6) ac = 4'd3;
            else if (f3 == 3'd4) ac = 4'd4;
            else if (f3 == 3'd2) ac = 4'd5;
            else if (w == 4) begin
                if (f3 == 3'd1)      ac = 4'd6;
                else if (f3 == 3'd5) ac = f7 ? 4'd8 : 4'd7;
                else                 ac = 4'd9;
            end
        end
        return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, ac, ill, 4'(st)};
    endfunction

    function automatic int nxt(int st, bit umr);
        logic rdy;
        rdy = umr ? mr : 1'b1;
        if (reset) return 0;
        case (st)
            0: return rdy ? 1 : 0;
            1: case (op)
                   7'b0000011, 7'b0100011: return 2;
                   7'b0110011:             return 6;
                   7'b0010011:             return 8;
                   7'b1101111:             return 9;
                   7'b1100011:             return 10;
                   default:                return 11;
               endcase
            2: return op[5] ? 5 : 3;
            3: return rdy ? 4 : 3;
            5: return rdy ? 0 : 5;
            6, 8, 9: return 7;
            default: return 0;
        endcase
    endfunction

    task automatic check();
        logic [22:0] e0, e1, g0, g1;
        e0 = model(st0, 3, 1'b0);
        e1 = model(st1, 4, 1'b1);
        g0 = {b0.PCWrite, b0.AdrSrc, b0.MemWrite, b0.IRWrite, b0.ResultSrc, b0.ALUSrcA, b0.ALUSrcB,
              b0.RegWrite, b0.ImmSrc, {1'b0, b0.ALUControl}, b0.IllegalOp, b0.StateDbg};
        g1 = {b1.PCWrite, b1.AdrSrc, b1.MemWrite, b1.IRWrite, b1.ResultSrc, b1.ALUSrcA, b1.ALUSrcB,
              b1.RegWrite, b1.ImmSrc, b1.ALUControl, b1.IllegalOp, b1.StateDbg};
        checks++;
        assert (g0 === e0) else begin
            errors++;
            $error("FAIL %s u0 observed=%h expected=%h", tag, g0, e0);
        end
        checks++;
        assert (g1 === e1) else begin
            errors++;
            $error("FAIL %s u1 observed=%h expected=%h", tag, g1, e1);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model across the edge.
    task automatic cyc();
        int n0, n1;
        @(negedge clk);
        check();
        n0 = nxt(st0, 1'b0);
        n1 = nxt(st1, 1'b1);
        @(posedge clk);
        #1;
        st0 = n0;
        st1 = n1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] fn3, input logic fn7,
                         input logic [31:0] va, input logic [31:0] vb, input int n);
        op = o; f3 = fn3; f7 = fn7; a = va; b = vb; mr = 1'b1;
        repeat (n) cyc();
    endtask

    logic [6:0] ops [10];

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0001111};
        reset = 1'b1; op = 7'b0000011; f3 = 3'd2; f7 = 1'b0; mr = 1'b1; a = 0; b = 0;
        @(posedge clk); #1;
        st0 = 0; st1 = 0;

        tag = "reset_hold";
        repeat (2) cyc();
        reset = 1'b0;

        tag = "lw";
        instr(7'b0000011, 3'd2, 1'b0, 32'd0, 32'd0, 6);

        tag = "sw_wait";
        do_reset();
        op = 7'b0100011; f3 = 3'd2; f7 = 1'b0;
        mr = 1'b0; repeat (2) cyc();   // FETCH stalls on u1
        mr = 1'b1; repeat (2) cyc();   // FETCH, DECODE
        cyc();                         // MEMADR
        mr = 1'b0; repeat (3) cyc();   // MEMWRITE stalled
        mr = 1'b1; repeat (2) cyc();   // last MEMWRITE, FETCH

        tag = "bne_taken";    do_reset(); instr(7'b1100011, 3'd1, 1'b0, 32'd5, 32'd3, 4);
        tag = "bne_not";      do_reset(); instr(7'b1100011, 3'd1, 1'b0, 32'd7, 32'd7, 4);
        tag = "bltu_taken";   do_reset(); instr(7'b1100011, 3'd6, 1'b0, 32'd1, 32'd2, 4);
        tag = "blt_neg";      do_reset(); instr(7'b1100011, 3'd4, 1'b0, 32'h8000_0000, 32'd1, 4);
        tag = "bf3_010";      do_reset(); instr(7'b1100011, 3'd2, 1'b0, 32'd1, 32'd1, 4);
        tag = "sub_r";        do_reset(); instr(7'b0110011, 3'd0, 1'b1, 32'd0, 32'd0, 5);
        tag = "addi_f7";      do_reset(); instr(7'b0010011, 3'd0, 1'b1, 32'd0, 32'd0, 5);
        tag = "sra";          do_reset(); instr(7'b0110011, 3'd5, 1'b1, 32'd0, 32'd0, 5);
        tag = "sltu_i";       do_reset(); instr(7'b0010011, 3'd3, 1'b0, 32'd0, 32'd0, 5);
        tag = "illegal";      do_reset(); instr(7'b1111111, 3'd0, 1'b0, 32'd0, 32'd0, 5);

        tag = "jal_reset_wb";
        do_reset();
        instr(7'b1101111, 3'd0, 1'b0, 32'd0, 32'd0, 3);  // FETCH, DECODE, JAL
        reset = 1'b1; cyc();                             // ALUWB with reset
        reset = 1'b0; repeat (2) cyc();                  // FETCH, no RegWrite

        tag = "random";
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = ops[$urandom_range(0, 9)];
                if ($urandom_range(0, 7) == 0) op = 7'($urandom);
                f3 = 3'($urandom);
                f7 = 1'($urandom);
                a  = $urandom;
                b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            end
            mr    = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 59) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised multicycle RV32I control unit: one FSM sequences fetch, decode, execute, memory and writeback over several clocks and drives the shared-memory multicycle datapath. Successor to the single-cycle controller. Adds:
- full branch-condition set (beq/bne/blt/bge/bltu/bgeu);
- optional memory-ready wait states;
- illegal-opcode detection;
- width-selectable ALU control encoding.

Parameters:
ALUCTRL_W, 3, ALUControl width; 3 = base op set, 4 = extended op set (shifts, sltu).
USE_MEM_READY, 0, 1 = FETCH/MEMREAD/MEMWRITE wait for MemReady; 0 = MemReady ignored (treated as 1).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
op  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU result == 0
Neg  in  1  ALU result sign bit
Carry  in  1  ALU carry-out of subtraction (1 = no borrow)
Overflow  in  1  ALU signed overflow
MemReady  in  1  memory access completes this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0 = PC, 1 = ALU result register as memory address
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register / OldPC enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4
RegWrite  out  1  register file write enable
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUControl  out  ALUCTRL_W  ALU operation
IllegalOp  out  1  one-cycle pulse on unsupported opcode
StateDbg  out  4  current state encoding

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. When reset is high at a rising edge, state goes to FETCH.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, ILLEGAL=11.
- Outputs are a Moore function of state, except:
  - PCWrite and IRWrite depend on MemReady (FETCH);
  - PCWrite also depends on the branch-taken condition (BRANCH);
  - ImmSrc and ALUControl are decoded from op/funct every cycle.
- Default output values: unlisted outputs are 0, ALUSrcA=00, ALUSrcB=00, ResultSrc=00.
- Output values while in FETCH (the reset state) — this is also the required output set in the cycle after reset:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10.
  - IRWrite=PCWrite=rdy, where rdy = MemReady | ~USE_MEM_READY.
  - FETCH→DECODE when rdy; otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, add; computes the branch/jal target. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BRANCH
  - any other opcode → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state is MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Go to MEMWB when rdy; otherwise hold.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 for every cycle spent in the state. Go to FETCH when rdy.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (rd ← OldPC+4).
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=taken, then FETCH. taken by funct3:
  - 000 Zero
  - 001 ~Zero
  - 100 Neg^Overflow
  - 101 ~(Neg^Overflow)
  - 110 ~Carry
  - 111 Carry
  - 010/011: taken=0
- ILLEGAL: IllegalOp=1 for exactly one cycle, no writes, then FETCH.
- ImmSrc by op:
  - 0100011 → S
  - 1100011 → B
  - 1101111 → J
  - 0110111/0010111 → U
  - otherwise → I
- ALUControl:
  - ALUOp add → 0; ALUOp sub → 1.
  - funct decode:
    - 000 → sub if op[5]&funct7b5, else add
    - 111 → and (2)
    - 110 → or (3)
    - 100 → xor (4)
    - 010 → slt (5)
  - ALUCTRL_W=4 additionally:
    - 001 → sll (6)
    - 101 → srl (7), or sra (8) if funct7b5
    - 011 → sltu (9)
  - ALUCTRL_W=3: unsupported funct3 → add (0).
- Reset mid-instruction (any state, including a wait): the next state is FETCH. No write strobe may be asserted in the cycle after reset.
- MemReady with USE_MEM_READY=0: every memory state lasts exactly 1 cycle.

Test Plan:
- Reset held 2 cycles, then lw (op 0000011), USE_MEM_READY=0 → states 0,1,2,3,4,0; RegWrite=1 only in MEMWB; ResultSrc=01 there.
- sw with USE_MEM_READY=1, MemReady low 3 cycles in MEMWRITE → MemWrite high 4 cycles, then FETCH; FETCH with MemReady=0 keeps IRWrite=PCWrite=0.
- bne (funct3 001) with Zero=0 → PCWrite=1 in BRANCH; the same instruction with Zero=1 → PCWrite=0. bltu with Carry=0 → PCWrite=1.
- R-type sub (funct3 000, funct7b5=1, op[5]=1) → ALUControl=1 in EXECR. addi with funct7b5=1 → ALUControl=0. ALUCTRL_W=4 sra → 8.
- op 1111111 → DECODE→ILLEGAL, IllegalOp single-cycle pulse, no RegWrite/MemWrite/PCWrite, then FETCH.
- jal → JAL state has PCWrite=1, ALUSrcA=01, ALUSrcB=10; next ALUWB has RegWrite=1; reset asserted during ALUWB → FETCH next cycle with RegWrite=0.
